// File: rtl/port_out_arbiter.sv
// -----------------------------------------------------------------------------
// port_out_arbiter
//
// Arbitrates four requesters (CPU core, DMA engine, sequencers) onto the single
// write interface of the 16-entry output port bank. Round-robin grant, bursts
// bounded to BURST_MAX accepted writes, address-window checking and a
// one-cycle acknowledge per accepted write.
//
// Parameters:
//   BURST_MAX  maximum accepted writes per grant (1..15)
//   ADDR_BASE  base of the 16-byte port window, low nibble must be zero
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   req        per-requester request level, held until its last write is acked
//   req_addr   requester i address at [8i+7:8i]
//   req_data   requester i data at [8i+7:8i]
//   req_last   requester i current write is the final one of its burst
//   gnt        registered one-hot grant
//   ack        one-cycle pulse, write of requester i accepted
//   err        one-cycle pulse, accepted write was outside the window (dropped)
//   address    port bank address
//   data_out   port bank write data
//   write      port bank write strobe, one cycle per forwarded write
//
// Configuration:
//   PORT_ARB_PRIO_EN  when defined, requester 0 wins every IDLE arbitration it
//                     takes part in; otherwise all requesters are equal.
// -----------------------------------------------------------------------------
module port_out_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter logic [7:0]  ADDR_BASE = 8'hE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic        err,
    output logic [7:0]  address,
    output logic [7:0]  data_out,
    output logic        write
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  ptr_r;
    logic [1:0]  ptr_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [3:0]  cnt_inc_s;
    logic [3:0]  gnt_r;
    logic [3:0]  gnt_nxt_s;
    logic [3:0]  ack_r;
    logic [3:0]  ack_nxt_s;
    logic        err_r;
    logic        err_nxt_s;
    logic        write_r;
    logic        write_nxt_s;
    logic [7:0]  address_r;
    logic [7:0]  address_nxt_s;
    logic [7:0]  data_r;
    logic [7:0]  data_nxt_s;

    logic [1:0]  owner_s;
    logic [1:0]  pick_s;
    logic        own_req_s;
    logic        own_last_s;
    logic [7:0]  own_addr_s;
    logic [7:0]  own_data_s;
    logic        in_window_s;
    logic        release_s;

    // One-hot grant to index; an illegal pattern maps to requester 0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // First set request bit searching upward from p, wrapping mod 4. The loop
    // runs downward so the closest candidate to p is the last one written.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Current owner view and release decision.
    always_comb begin
        owner_s     = onehot_to_idx(gnt_r);
        own_req_s   = req[owner_s];
        own_last_s  = req_last[owner_s];
        own_addr_s  = req_addr[{owner_s, 3'b000} +: 8];
        own_data_s  = req_data[{owner_s, 3'b000} +: 8];
        in_window_s = (own_addr_s[7:4] == ADDR_BASE[7:4]);
        // Saturating increment keeps cnt at BURST_MAX until IDLE clears it.
        if (cnt_r >= BURST_LIMIT) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 4'd1;
        end
        // A dropped request releases without an acceptance.
        release_s = !own_req_s || own_last_s || (cnt_inc_s >= BURST_LIMIT);
    end

    // Arbitration winner for the IDLE state.
    always_comb begin
`ifdef PORT_ARB_PRIO_EN
        if (req[0]) begin
            pick_s = 2'd0;
        end else begin
            pick_s = rr_pick(req, ptr_r);
        end
`else
        pick_s = rr_pick(req, ptr_r);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_nxt_s = ST_TURN;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_TURN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; pulses default low every cycle.
    always_comb begin
        gnt_nxt_s     = gnt_r;
        ack_nxt_s     = 4'b0000;
        err_nxt_s     = 1'b0;
        write_nxt_s   = 1'b0;
        address_nxt_s = address_r;
        data_nxt_s    = data_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 4'd0;
                if (|req) begin
                    gnt_nxt_s = idx_to_onehot(pick_s);
                end else begin
                    gnt_nxt_s = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (own_req_s) begin
                    ack_nxt_s = idx_to_onehot(owner_s);
                    cnt_nxt_s = cnt_inc_s;
                    if (in_window_s) begin
                        write_nxt_s   = 1'b1;
                        address_nxt_s = own_addr_s;
                        data_nxt_s    = own_data_s;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (release_s) begin
                    gnt_nxt_s = 4'b0000;
                    ptr_nxt_s = owner_s + 2'd1;
                end else begin
                    gnt_nxt_s = gnt_r;
                end
            end
            ST_TURN: begin
                gnt_nxt_s = 4'b0000;
            end
            default: begin
                gnt_nxt_s = 4'b0000;
            end
        endcase
    end

    // Registered outputs, pointer and burst counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_r     <= 4'b0000;
            ack_r     <= 4'b0000;
            err_r     <= 1'b0;
            write_r   <= 1'b0;
            address_r <= 8'h00;
            data_r    <= 8'h00;
            ptr_r     <= 2'd0;
            cnt_r     <= 4'd0;
        end else begin
            gnt_r     <= gnt_nxt_s;
            ack_r     <= ack_nxt_s;
            err_r     <= err_nxt_s;
            write_r   <= write_nxt_s;
            address_r <= address_nxt_s;
            data_r    <= data_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign gnt      = gnt_r;
    assign ack      = ack_r;
    assign err      = err_r;
    assign write    = write_r;
    assign address  = address_r;
    assign data_out = data_r;

endmodule

// File: tb/tb_port_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_port_out_arbiter
//
// Directed bench for port_out_arbiter with default parameters (BURST_MAX=4,
// ADDR_BASE=8'hE0). A small requester model raises/holds/drops req and
// req_last in reaction to ack, and logs grant order and the number of idle
// grant cycles before each new grant.
// -----------------------------------------------------------------------------
module tb_port_out_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        err;
    logic [7:0]  address;
    logic [7:0]  data_out;
    logic        write;

    int tests_run    = 0;
    int tests_failed = 0;

    // Requester model state
    int         burst_len   [4];
    int         bursts_left [4];
    int         wr_cnt      [4];
    int         ack_count   [4];
    int         grant_log   [$];
    int         gap_log     [$];
    int         low_cnt;
    logic [3:0] prev_gnt;

    port_out_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .address  (address),
        .data_out (data_out),
        .write    (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int oh_idx(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        req      = 4'b0000;
        req_last = 4'b0000;
        req_addr = 32'h0000_0000;
        req_data = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            burst_len[i]   = 0;
            bursts_left[i] = 0;
            wr_cnt[i]      = 0;
            ack_count[i]   = 0;
        end
        grant_log.delete();
        gap_log.delete();
        low_cnt  = 0;
        prev_gnt = 4'b0000;
    endtask

    // len = writes per burst (0 = never marks last), nb = number of bursts
    task automatic start_req(input int i, input int len, input int nb,
                             input logic [7:0] a, input logic [7:0] d);
        req_addr[i*8 +: 8] = a;
        req_data[i*8 +: 8] = d;
        burst_len[i]       = len;
        bursts_left[i]     = nb;
        wr_cnt[i]          = 0;
        req_last[i]        = (len == 1);
        req[i]             = 1'b1;
    endtask

    // Called once per negedge after sampling: log grants, react to acks.
    task automatic model_step();
        if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
            grant_log.push_back(oh_idx(gnt));
            gap_log.push_back(low_cnt);
        end
        if (gnt == 4'b0000) low_cnt++;
        else                low_cnt = 0;
        prev_gnt = gnt;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                ack_count[i]++;
                if (burst_len[i] != 0) begin
                    wr_cnt[i]++;
                    if (wr_cnt[i] >= burst_len[i]) begin
                        wr_cnt[i] = 0;
                        bursts_left[i]--;
                        if (bursts_left[i] <= 0) begin
                            req[i]      = 1'b0;
                            req_last[i] = 1'b0;
                        end else begin
                            req_last[i] = (burst_len[i] == 1);
                        end
                    end else begin
                        req_last[i] = (wr_cnt[i] == burst_len[i] - 1);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        tests_run += 6;
        if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b want 0000", ack); end
        if (err !== 1'b0)    begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
        if (write !== 1'b0)  begin tests_failed++; $display("FAIL reset_write: got %b want 0", write); end
        if (address !== 8'h00)  begin tests_failed++; $display("FAIL reset_address: got %h want 00", address); end
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data_out); end
        req = 4'b0000;
    endtask

    task automatic test_single_write();
        do_reset();
        req_addr[23:16] = 8'hE5;
        req_data[23:16] = 8'hA7;
        req_last[2]     = 1'b1;
        req[2]          = 1'b1;
        @(negedge clk);
        tests_run += 3;
        if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL single_ack_early: got %b want 0000", ack); end
        if (write !== 1'b0)  begin tests_failed++; $display("FAIL single_write_early: got %b want 0", write); end
        @(negedge clk);
        tests_run += 6;
        if (write !== 1'b1)     begin tests_failed++; $display("FAIL single_write: got %b want 1", write); end
        if (address !== 8'hE5)  begin tests_failed++; $display("FAIL single_address: got %h want e5", address); end
        if (data_out !== 8'hA7) begin tests_failed++; $display("FAIL single_data: got %h want a7", data_out); end
        if (ack !== 4'b0100)    begin tests_failed++; $display("FAIL single_ack: got %b want 0100", ack); end
        if (err !== 1'b0)       begin tests_failed++; $display("FAIL single_err: got %b want 0", err); end
        if (gnt !== 4'b0000)    begin tests_failed++; $display("FAIL single_release: got %b want 0000", gnt); end
        req         = 4'b0000;
        req_last[2] = 1'b0;
        @(negedge clk);
        tests_run += 3;
        if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL single_turn_gnt: got %b want 0000", gnt); end
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL single_turn_ack: got %b want 0000", ack); end
        if (write !== 1'b0)  begin tests_failed++; $display("FAIL single_turn_write: got %b want 0", write); end
    endtask

    task automatic test_round_robin();
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        start_req(0, 2, 2, 8'hE0, 8'h10);
        start_req(1, 2, 1, 8'hE1, 8'h11);
        start_req(2, 2, 1, 8'hE2, 8'h12);
        start_req(3, 2, 1, 8'hE3, 8'h13);
        for (int c = 0; c < 200 && grant_log.size() < 5; c++) begin
            @(negedge clk);
            model_step();
        end
        tests_run++;
        if (grant_log.size() < 5) begin
            tests_failed++;
            $display("FAIL rr_timeout: got %0d grants want 5", grant_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (grant_log[k] !== exp_order[k]) begin
                    tests_failed++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_log[k], exp_order[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                tests_run++;
                if (gap_log[k] !== 2) begin
                    tests_failed++;
                    $display("FAIL rr_gap[%0d]: got %0d want 2", k, gap_log[k]);
                end
            end
        end
    endtask

    task automatic test_burst_limit();
        int exp_order [5];
        int run;
        int max_run;
        int acks_at_release;
        bit others;
        exp_order       = '{1, 2, 3, 0, 1};
        run             = 0;
        max_run         = 0;
        acks_at_release = -1;
        others          = 1'b0;
        do_reset();
        start_req(1, 0, 1, 8'hE9, 8'h99);
        for (int c = 0; c < 200 && grant_log.size() < 5; c++) begin
            @(negedge clk);
            if (ack[1]) run++;
            else        run = 0;
            if (run > max_run) max_run = run;
            model_step();
            if (!others && gnt == 4'b0010) begin
                start_req(0, 1, 1, 8'hE0, 8'h01);
                start_req(2, 1, 1, 8'hE2, 8'h02);
                start_req(3, 1, 1, 8'hE3, 8'h03);
                others = 1'b1;
            end
            if (grant_log.size() == 2 && acks_at_release < 0) acks_at_release = ack_count[1];
        end
        tests_run += 3;
        if (max_run !== 4) begin tests_failed++; $display("FAIL burst_b2b_acks: got %0d want 4", max_run); end
        if (acks_at_release !== 4) begin tests_failed++; $display("FAIL burst_acks: got %0d want 4", acks_at_release); end
        if (grant_log.size() < 5) begin
            tests_failed++;
            $display("FAIL burst_timeout: got %0d grants want 5", grant_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (grant_log[k] !== exp_order[k]) begin
                    tests_failed++;
                    $display("FAIL burst_order[%0d]: got %0d want %0d", k, grant_log[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_bad_addr();
        bit seen;
        seen = 1'b0;
        do_reset();
        start_req(3, 1, 1, 8'hE2, 8'h3C);
        for (int c = 0; c < 20 && ack_count[3] < 1; c++) begin
            @(negedge clk);
            model_step();
        end
        start_req(0, 1, 1, 8'hF3, 8'h55);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ack[0]) begin
                seen = 1'b1;
                tests_run += 5;
                if (ack !== 4'b0001)    begin tests_failed++; $display("FAIL bad_ack: got %b want 0001", ack); end
                if (err !== 1'b1)       begin tests_failed++; $display("FAIL bad_err: got %b want 1", err); end
                if (write !== 1'b0)     begin tests_failed++; $display("FAIL bad_write: got %b want 0", write); end
                if (address !== 8'hE2)  begin tests_failed++; $display("FAIL bad_address: got %h want e2", address); end
                if (data_out !== 8'h3C) begin tests_failed++; $display("FAIL bad_data: got %h want 3c", data_out); end
            end
            model_step();
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL bad_timeout: got no ack want ack[0]"); end
        @(negedge clk);
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL bad_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        start_req(2, 1, 1, 8'hE2, 8'h22);
        for (int c = 0; c < 20 && ack_count[2] < 1; c++) begin
            @(negedge clk);
            model_step();
        end
        start_req(1, 0, 1, 8'hE4, 8'h44);
        for (int c = 0; c < 30 && ack_count[1] < 2; c++) begin
            @(negedge clk);
            model_step();
        end
        tests_run++;
        if (ack_count[1] !== 2) begin tests_failed++; $display("FAIL rst_mid_setup: got %0d acks want 2", ack_count[1]); end
        reset = 1'b0;
        #1;
        tests_run += 6;
        if (gnt !== 4'b0000)    begin tests_failed++; $display("FAIL rst_mid_gnt: got %b want 0000", gnt); end
        if (ack !== 4'b0000)    begin tests_failed++; $display("FAIL rst_mid_ack: got %b want 0000", ack); end
        if (err !== 1'b0)       begin tests_failed++; $display("FAIL rst_mid_err: got %b want 0", err); end
        if (write !== 1'b0)     begin tests_failed++; $display("FAIL rst_mid_write: got %b want 0", write); end
        if (address !== 8'h00)  begin tests_failed++; $display("FAIL rst_mid_address: got %h want 00", address); end
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_data: got %h want 00", data_out); end
        @(negedge clk);
        tests_run++;
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL rst_mid_no_ack: got %b want 0000", ack); end
        model_clear();
        start_req(0, 1, 1, 8'hE0, 8'h01);
        start_req(1, 1, 1, 8'hE1, 8'h02);
        start_req(3, 1, 1, 8'hE3, 8'h03);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL rst_mid_first_gnt: got %b want 0001", gnt); end
    endtask

    task automatic test_prio();
        logic [3:0] exp_gnt;
`ifdef PORT_ARB_PRIO_EN
        exp_gnt = 4'b0001;
`else
        exp_gnt = 4'b0100;
`endif
        do_reset();
        start_req(1, 1, 1, 8'hE1, 8'h11);
        for (int c = 0; c < 20 && ack_count[1] < 1; c++) begin
            @(negedge clk);
            model_step();
        end
        // ptr is now 2; requests appear on the release edge's following cycle
        start_req(0, 1, 1, 8'hE0, 8'h01);
        start_req(2, 1, 1, 8'hE2, 8'h02);
        start_req(3, 1, 1, 8'hE3, 8'h03);
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL prio_turn_gnt: got %b want 0000", gnt); end
        @(negedge clk);
        tests_run++;
        if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL prio_gnt: got %b want %b", gnt, exp_gnt); end
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        req_addr = 32'h0000_0000;
        req_data = 32'h0000_0000;
        req_last = 4'b0000;
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst_limit();
        test_bad_addr();
        test_reset_mid_burst();
        test_prio();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/port_out_arbiter.md
# port_out_arbiter

Arbitrates the memory-mapped output-port write bus between four requesters, such as the CPU core, a DMA engine and sequencers, and drives the single address, data and write interface of the 16-entry output port bank at 8'hE0–8'hEF. Round-robin grant with bounded bursts, address-window checking and a per-write acknowledge. Sits between the requesters and the port bank, whose write inputs it owns exclusively.

## Interface
- `BURST_MAX`, default 4: maximum accepted writes per grant (1–15).
- `ADDR_BASE`, default 8'hE0: base of the 16-byte port window. Bits [3:0] must be 0.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 4: request per requester. Level, held until its last write is acked.
- `req_addr` in 32: requester i address at [8i+7:8i].
- `req_data` in 32: requester i data at [8i+7:8i].
- `req_last` in 4: marks requester i's current write as final of burst.
- `gnt` out 4: one-hot grant, registered.
- `ack` out 4: one-cycle pulse, write of requester i accepted.
- `err` out 1: one-cycle pulse, accepted write was outside window (dropped).
- `address` out 8: to port bank.
- `data_out` out 8: to port bank `data_in`.
- `write` out 1: to port bank, one-cycle strobe per forwarded write.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE: if any `req` high, select the first set bit searching from `ptr` upward, mod 4. Set `gnt` one-hot and go to GRANT. Clear `cnt`. Else stay.
- GRANT (owner o): each cycle `req[o]`=1 is an accepted write.
  - Pulse `ack[o]`.
  - `cnt` = `cnt` + 1.
  - If `req_addr[o]`[7:4] == `ADDR_BASE`[7:4]: register `address`/`data_out` from requester o and pulse `write`. Else pulse `err`, with `write` low.
- Release from GRANT when any of these holds, then go to TURN, set `ptr` = o+1 mod 4, and clear `gnt`:
  - the accepted write has `req_last[o]`=1;
  - `cnt` reaches `BURST_MAX`;
  - `req[o]` is sampled low.
- TURN: one dead cycle. No write, `gnt`=0. Then IDLE.
- `ack`/`write`/`err` never assert outside GRANT acceptance. At most one `gnt` bit set, ever.
- Requests arriving mid-burst wait. A requester that drops `req` loses its turn.
- `cnt` is 4-bit and saturates at `BURST_MAX`, then is cleared in IDLE.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `cnt`=0;
  - `gnt`=4'b0, `ack`=4'b0, `err`=0;
  - `address`=8'h00, `data_out`=8'h00, `write`=0.
- Reset is effective immediately, including mid-burst. The in-flight write is dropped and no `ack` is issued.
- Request to grant: `req` high before edge N gives `gnt` high after edge N.
- First acceptance at edge N+1 gives `ack`/`write`/`address`/`data_out` valid after N+1. The port bank captures at N+2.
- Back-to-back writes at one per cycle while granted.
- Grant-to-grant gap is 2 cycles minimum: the release edge, then TURN.
- Release and a new request on the same edge: the new request is seen in IDLE after TURN.

## Configuration
- `PORT_ARB_PRIO_EN` defined: at every IDLE arbitration, requester 0 wins if `req[0]`=1, regardless of `ptr`. Otherwise round-robin. Never preempts an active burst.
- Undefined: pure round-robin. All requesters are equal.

## Test plan
- Single write, requester 2 at 8'hE5, data 8'hA7, `req_last`=1:
  - `gnt`=4'b0100 one cycle after `req`;
  - next cycle `write`=1, `address`=E5, `data_out`=A7, `ack`=4'b0100;
  - then TURN, then IDLE.
- All four request bursts of 2 from reset: grant order 0,1,2,3,0, with a 2-cycle gap between grants.
- Requester 1 holds `req` without `req_last`, `BURST_MAX`=4: exactly 4 acks, then release. Requester 1 is regranted only after the others are served.
- Write to 8'hF3: `ack` pulses, `err`=1, `write`=0, port-bank outputs unchanged.
- `reset` low mid-burst after 2 writes: all outputs go to reset values immediately. After release, requester 0 is granted first.
- With `PORT_ARB_PRIO_EN`, `ptr`=2, `req`=4'b1101: requester 0 granted. Without it, requester 2 granted.
